// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the MEM-stage access controller: access widths,
// FSM states and the default ack timeout.
package mem_ctrl_pkg;
  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;
endpackage

// File: rtl/load_filter.sv
// Picks the addressed byte/half out of a little-endian read word and
// sign- or zero-extends it; word accesses pass straight through.
module load_filter
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_width,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (i_addr)
      2'd0:    byte_sel = i_rdata[7:0];
      2'd1:    byte_sel = i_rdata[15:8];
      2'd2:    byte_sel = i_rdata[23:16];
      default: byte_sel = i_rdata[31:24];
    endcase
    half_sel = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_width)
      WIDTH_BYTE: o_data = {{24{byte_sel[7] & ~i_unsigned}}, byte_sel};
      WIDTH_HALF: o_data = {{16{half_sel[15] & ~i_unsigned}}, half_sel};
      default:    o_data = i_rdata;
    endcase
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: accepts one LUI/load/store from EX/MEM, runs the
// data-memory req/ack handshake, and registers the writeback value.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int BITS_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_lui,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [1:0]           i_width,
  input  logic                 i_unsigned,
  input  logic [BITS_SIZE-1:0] i_addr,
  input  logic [BITS_SIZE-1:0] i_wdata,
  input  logic [BITS_SIZE-1:0] i_extension,
  output logic                 o_stall,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [BITS_SIZE-1:0] o_mem_addr,
  output logic [3:0]           o_mem_be,
  output logic [BITS_SIZE-1:0] o_mem_wdata,
  input  logic                 i_mem_ack,
  input  logic [BITS_SIZE-1:0] i_mem_rdata,
  output logic [BITS_SIZE-1:0] o_result,
  output logic                 o_result_valid,
  output logic                 o_misaligned,
  output logic                 o_timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BITS_SIZE-1:0] addr_q, addr_d, wdata_q, wdata_d, result_q, result_d;
  logic [1:0]           width_q, width_d;
  logic                 uns_q, uns_d, we_q, we_d;
  logic [3:0]           be_q, be_d;
  logic                 rv_q, rv_d, mis_q, mis_d, tmo_q, tmo_d;

  logic                 mem_op, misaligned, accept, in_req, last_wait;
  logic [BITS_SIZE-1:0] load_data;

  assign mem_op     = i_mem_read | i_mem_write;
  assign misaligned = ((i_width == WIDTH_HALF) & i_addr[0]) | (i_width[1] & (|i_addr[1:0]));
  assign accept     = (state_q == ST_IDLE) & i_valid & ~i_lui & mem_op & ~misaligned;
  assign in_req     = (state_q == ST_REQ);
  assign last_wait  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Low in the ack/timeout cycle so the pipeline advances on that edge.
  assign o_stall = accept | (in_req & ~i_mem_ack & ~last_wait);

  load_filter u_load_filter (
    .i_rdata    (i_mem_rdata),
    .i_addr     (addr_q[1:0]),
    .i_width    (width_q),
    .i_unsigned (uns_q),
    .o_data     (load_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    width_d  = width_q;
    uns_d    = uns_q;
    we_d     = we_q;
    be_d     = be_q;
    result_d = result_q;
    rv_d     = 1'b0;
    mis_d    = 1'b0;
    tmo_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (i_lui) begin
            result_d = i_extension;
            rv_d     = 1'b1;
          end else if (mem_op && misaligned) begin
            mis_d = 1'b1;
          end else if (mem_op) begin
            state_d = ST_REQ;
            cnt_d   = '0;
            addr_d  = i_addr;
            width_d = i_width;
            uns_d   = i_unsigned;
            we_d    = ~i_mem_read;  // read wins when both are set
            case (i_width)
              WIDTH_BYTE: begin
                be_d    = 4'b0001 << i_addr[1:0];
                wdata_d = {4{i_wdata[7:0]}};
              end
              WIDTH_HALF: begin
                be_d    = 4'b0011 << i_addr[1:0];
                wdata_d = {2{i_wdata[15:0]}};
              end
              default: begin
                be_d    = 4'b1111;
                wdata_d = i_wdata;
              end
            endcase
          end
        end
      end
      default: begin
        if (i_mem_ack) begin
          state_d = ST_IDLE;
          if (!we_q) begin
            result_d = load_data;
            rv_d     = 1'b1;
          end
        end else if (last_wait) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      width_q  <= '0;
      uns_q    <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      mis_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      width_q  <= width_d;
      uns_q    <= uns_d;
      we_q     <= we_d;
      be_q     <= be_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      mis_q    <= mis_d;
      tmo_q    <= tmo_d;
    end
  end

  assign o_mem_req      = in_req;
  assign o_mem_we       = we_q;
  assign o_mem_addr     = {addr_q[BITS_SIZE-1:2], 2'b00};
  assign o_mem_be       = be_q;
  assign o_mem_wdata    = wdata_q;
  assign o_result       = result_q;
  assign o_result_valid = rv_q;
  assign o_misaligned   = mis_q;
  assign o_timeout      = tmo_q;
endmodule
